acc_mult_ctrl: RTL and testbench

Control FSM for the shift-and-add multiplier built around the 9-bit `ACC` accumulator register. On a start request it issues the `load`, `ad` and `sh` strobes to `ACC` in the correct order. For each of the N multiplier bits it decides, from the accumulator LSB, whether to add before shifting. When the product is complete it reports with a one-cycle `done` pulse. It sits between the system start logic and the `ACC` plus adder datapath, and is the only driver of the `ACC` control inputs.

---
 rtl/acc_mult_ctrl.sv | 88 ++++++++
 tb/tb_acc_mult_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/acc_mult_ctrl.sv
// Control FSM for the shift-and-add multiplier around the ACC register.
// Sequences load, then per multiplier bit an optional add followed by a shift, then a done pulse.
module acc_mult_ctrl #(
  parameter int N_BITS = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_st,
  input  logic i_m,
  output logic o_load,
  output logic o_ad,
  output logic o_sh,
  output logic o_busy,
  output logic o_done
);

  localparam int CW = $clog2(N_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // TEST is Mealy on i_m: the add/shift choice comes straight from the ACC LSB.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_load      = 1'b0;
    o_ad        = 1'b0;
    o_sh        = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_st) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        o_load      = 1'b1;
        o_busy      = 1'b1;
        w_cnt_nxt   = '0;
        w_state_nxt = S_TEST;
      end
      S_TEST: begin
        o_busy = 1'b1;
        if (i_m) begin
          o_ad        = 1'b1;
          w_state_nxt = S_SHIFT;
        end else begin
          o_sh        = 1'b1;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_state_nxt = w_last ? S_DONE : S_TEST;
        end
      end
      S_SHIFT: begin
        o_busy      = 1'b1;
        o_sh        = 1'b1;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_state_nxt = w_last ? S_DONE : S_TEST;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_acc_mult_ctrl.sv
// Bench for acc_mult_ctrl: closed loop with an ACC + adder model, strobe sequence
// predicted per operation from the multiplier bits and checked every cycle.
module tb_acc_mult_ctrl;
  localparam int N  = 4;
  localparam int AW = 2*N + 1;

  localparam logic [4:0] E_IDLE = 5'b00000;
  localparam logic [4:0] E_LOAD = 5'b10010;
  localparam logic [4:0] E_AD   = 5'b01010;
  localparam logic [4:0] E_SH   = 5'b00110;
  localparam logic [4:0] E_DONE = 5'b00001;

  logic clk = 1'b0;
  logic rst, st, m;
  logic o_load, o_ad, o_sh, o_busy, o_done;

  logic [AW-1:0] acc;
  logic [N-1:0]  mcand, mplier;
  logic          m_rand_en, m_rand;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic       chk_en = 1'b0;

  int cyc_abs = 0;
  int op_cyc = 0, n_ad = 0, n_sh = 0;
  int done_cyc = 0, done_ad = 0, done_sh = 0, done_busy = 0;
  int last_done_abs = 0, load_gap = 0;

  acc_mult_ctrl #(.N_BITS(N)) dut (
    .i_clk(clk), .i_rst(rst), .i_st(st), .i_m(m),
    .o_load(o_load), .o_ad(o_ad), .o_sh(o_sh), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  assign m = m_rand_en ? m_rand : acc[0];

  // ACC register plus (N+1)-bit adder, driven only by the DUT strobes
  always @(posedge clk) begin
    if (o_load)    acc <= {{(N+1){1'b0}}, mplier};
    else if (o_ad) acc <= {(acc[AW-1:N] + {1'b0, mcand}), acc[N-1:0]};
    else if (o_sh) acc <= acc >> 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // Expected per-cycle outputs of one operation, starting at the IDLE cycle that samples st.
  task automatic push_op(input logic [N-1:0] mp);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_LOAD);
    for (int i = 0; i < N; i++) begin
      if (mp[i]) exp_q.push_back(E_AD);
      exp_q.push_back(E_SH);
    end
    exp_q.push_back(E_DONE);
  endtask

  always @(negedge clk) begin
    logic [4:0] v, e;
    if (chk_en) begin
      cyc_abs++;
      v = {o_load, o_ad, o_sh, o_busy, o_done};
      e = (exp_q.size() != 0) ? exp_q.pop_front() : E_IDLE;
      chk("outs", {27'd0, v}, {27'd0, e});
      chk("strobe_onehot", {31'd0, ($countones({o_load, o_ad, o_sh}) <= 1)}, 32'd1);
      if (o_load) begin
        op_cyc = 1; n_ad = 0; n_sh = 0;
        load_gap = cyc_abs - last_done_abs;
      end else if (op_cyc != 0) op_cyc++;
      if (o_ad) n_ad++;
      if (o_sh) n_sh++;
      if (o_done) begin
        done_cyc = op_cyc; done_ad = n_ad; done_sh = n_sh;
        done_busy = int'(o_busy);
        last_done_abs = cyc_abs;
        op_cyc = 0;
      end
    end
  end

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_op(input logic [N-1:0] mc, input logic [N-1:0] mp, input int stw);
    @(posedge clk); #1;
    mcand = mc; mplier = mp; st = 1'b1;
    push_op(mp);
    repeat (stw) @(posedge clk);
    #1 st = 1'b0;
    wait_drain();
    chk("product", {23'd0, acc}, 32'(mc) * 32'(mp));
  endtask

  initial begin
    logic [4:0] e0;
    rst = 1'b1; st = 1'b0; m_rand_en = 1'b1; m_rand = 1'b0;
    mcand = '0; mplier = '0; acc = '0;

    // reset held 2 cycles with random st/m
    st = 1'($urandom); m_rand = 1'($urandom);
    @(posedge clk); #1;
    chk_en = 1'b1;
    st = 1'($urandom); m_rand = 1'($urandom);
    @(posedge clk); #1;
    rst = 1'b0; st = 1'b0; m_rand_en = 1'b0;
    repeat (3) @(posedge clk);

    // 1101 x 1011: literal pins on timing, counts and product
    run_op(4'b1011, 4'b1101, 1);
    chk("done_cyc_1101", done_cyc, 9);
    chk("ad_cnt_1101", done_ad, 3);
    chk("sh_cnt_1101", done_sh, 4);
    chk("busy_at_done", done_busy, 0);
    chk("product_143", {23'd0, acc}, 32'd143);

    run_op(4'b0110, 4'b0000, 1);
    chk("done_cyc_0000", done_cyc, 6);
    chk("ad_cnt_0000", done_ad, 0);

    run_op(4'b1111, 4'b1111, 2);
    chk("done_cyc_1111", done_cyc, 10);
    chk("ad_cnt_1111", done_ad, 4);

    // reset during second SHIFT (cycle 5 of a 1111 operation)
    @(posedge clk); #1;
    mcand = 4'b1011; mplier = 4'b1111; st = 1'b1;
    push_op(4'b1111);
    @(posedge clk); #1 st = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    e0 = exp_q[0];
    exp_q.delete();
    exp_q.push_back(e0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {27'd0, o_load, o_ad, o_sh, o_busy, o_done}, 32'd0);
    run_op(4'b1011, 4'b1111, 1);
    chk("after_rst_done_cyc", done_cyc, 10);
    chk("after_rst_sh_cnt", done_sh, 4);

    // st held high: restart 2 cycles after done
    @(posedge clk); #1;
    mcand = 4'b0101; mplier = 4'b1000; st = 1'b1;
    push_op(4'b1000);
    push_op(4'b1000);
    repeat (9) @(posedge clk);
    #1 st = 1'b0;
    wait_drain();
    chk("restart_gap", load_gap, 2);
    chk("restart_product", {23'd0, acc}, 32'd40);

    // randomized operations, st width 1..3, idle gaps 0..2
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      run_op(N'($urandom), N'($urandom), $urandom_range(1, 3));
      chk("rand_sh_cnt", done_sh, N);
    end

    repeat (3) @(posedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
